// File: rtl/crtc_timing_gen.sv
// 6845-style CRTC timing generator: character/row/scanline counters, syncs,
// display enable, memory/row address and a blinking hardware cursor.
module crtc_timing_gen #(
    parameter int unsigned H_WIDTH    = 8,
    parameter int unsigned V_WIDTH    = 7,
    parameter int unsigned RA_WIDTH   = 5,
    parameter int unsigned MA_WIDTH   = 14,
    parameter int unsigned SYNC_WIDTH = 4
) (
    input  logic                  cclk_i,
    input  logic                  reset_n_i,
    input  logic [MA_WIDTH-1:0]   screen_addr_i,
    input  logic [H_WIDTH-1:0]    h_char_total_i,
    input  logic [H_WIDTH-1:0]    h_char_displayed_i,
    input  logic [H_WIDTH-1:0]    h_sync_start_i,
    input  logic [SYNC_WIDTH-1:0] h_sync_width_i,
    input  logic [RA_WIDTH-1:0]   v_char_pixel_size_i,
    input  logic [V_WIDTH-1:0]    v_char_total_i,
    input  logic [V_WIDTH-1:0]    v_char_displayed_i,
    input  logic [V_WIDTH-1:0]    v_sync_start_i,
    input  logic [SYNC_WIDTH-1:0] v_sync_width_i,
    input  logic [RA_WIDTH-1:0]   v_adjust_i,
    input  logic [MA_WIDTH-1:0]   cursor_addr_i,
    input  logic [RA_WIDTH-1:0]   cursor_start_i,
    input  logic [RA_WIDTH-1:0]   cursor_end_i,
    input  logic [1:0]            cursor_mode_i,
    output logic                  display_enable_o,
    output logic                  h_sync_o,
    output logic                  v_sync_o,
    output logic [MA_WIDTH-1:0]   ma_o,
    output logic [RA_WIDTH-1:0]   ra_o,
    output logic                  cursor_o,
    output logic                  frame_start_o
);

    localparam int unsigned HW1  = H_WIDTH + 1;
    localparam int unsigned RAW1 = RA_WIDTH + 1;
    localparam int unsigned FC_W = 5;

    logic [H_WIDTH-1:0]    h_count,   h_count_nxt;
    logic [RA_WIDTH-1:0]   ra,        ra_nxt;
    logic [V_WIDTH-1:0]    row,       row_nxt;
    logic                  adj,       adj_nxt;
    logic [MA_WIDTH-1:0]   row_start, row_start_nxt;
    logic [SYNC_WIDTH-1:0] vs_count,  vs_count_nxt;
    logic [FC_W-1:0]       frame_cnt, frame_cnt_nxt;

    logic line_end;
    logic ra_last;
    logic frame_end;
    logic vs_load;

    // Next-state: horizontal wrap, scanline/row/adjust sequencing, frame end
    always_comb begin
        h_count_nxt   = h_count + H_WIDTH'(1);
        ra_nxt        = ra;
        row_nxt       = row;
        adj_nxt       = adj;
        row_start_nxt = row_start;
        frame_cnt_nxt = frame_cnt;
        vs_count_nxt  = vs_count;
        frame_end     = 1'b0;

        line_end = (h_count >= h_char_total_i);
        // ra + 1 >= v_adjust avoids the underflow of v_adjust - 1 if it is reprogrammed to 0
        ra_last  = adj ? (({1'b0, ra} + RAW1'(1)) >= {1'b0, v_adjust_i})
                       : (ra >= v_char_pixel_size_i);

        if (line_end) begin
            h_count_nxt = '0;
            if (ra_last) begin
                ra_nxt = '0;
                if (adj) begin
                    frame_end = 1'b1;
                end else begin
                    row_start_nxt = row_start + MA_WIDTH'(h_char_displayed_i);
                    if (row >= v_char_total_i) begin
                        if (v_adjust_i == '0) frame_end = 1'b1;
                        else                  adj_nxt   = 1'b1;
                    end else begin
                        row_nxt = row + V_WIDTH'(1);
                    end
                end
            end else begin
                ra_nxt = ra + RA_WIDTH'(1);
            end
        end

        if (frame_end) begin
            row_nxt       = '0;
            ra_nxt        = '0;
            adj_nxt       = 1'b0;
            row_start_nxt = screen_addr_i;
            frame_cnt_nxt = frame_cnt + FC_W'(1);
        end

        // Load on entry to the sync row so v_sync_o rises in the row's first cycle
        vs_load = (h_count_nxt == '0) && (ra_nxt == '0) &&
                  (row_nxt == v_sync_start_i) && !adj_nxt;
        if (vs_load)
            vs_count_nxt = v_sync_width_i;
        else if (line_end && (vs_count != '0))
            vs_count_nxt = vs_count - SYNC_WIDTH'(1);
    end

    always_ff @(posedge cclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            h_count   <= '0;
            ra        <= '0;
            row       <= '0;
            adj       <= 1'b0;
            row_start <= '0;
            vs_count  <= '0;
            frame_cnt <= '0;
        end else begin
            h_count   <= h_count_nxt;
            ra        <= ra_nxt;
            row       <= row_nxt;
            adj       <= adj_nxt;
            row_start <= row_start_nxt;
            vs_count  <= vs_count_nxt;
            frame_cnt <= frame_cnt_nxt;
        end
    end

    logic [HW1-1:0] hs_end;
    logic           blink_on;

    always_comb begin
        blink_on = 1'b0;
        case (cursor_mode_i)
            2'b00:   blink_on = 1'b1;
            2'b01:   blink_on = 1'b0;
            2'b10:   blink_on = !frame_cnt[3];
            default: blink_on = !frame_cnt[4];
        endcase
    end

    // Output decodes of the counter state
    assign hs_end           = {1'b0, h_sync_start_i} + HW1'(h_sync_width_i);
    assign ma_o             = row_start + MA_WIDTH'(h_count);
    assign ra_o             = ra;
    assign display_enable_o = reset_n_i && (h_count < h_char_displayed_i) &&
                              (row < v_char_displayed_i) && !adj;
    assign h_sync_o         = reset_n_i && (h_count >= h_sync_start_i) &&
                              ({1'b0, h_count} < hs_end);
    assign v_sync_o         = (vs_count != '0);
    assign cursor_o         = display_enable_o && (ma_o == cursor_addr_i) &&
                              (ra >= cursor_start_i) && (ra <= cursor_end_i) && blink_on;
    assign frame_start_o    = reset_n_i && (h_count == '0) && (ra == '0) &&
                              (row == '0) && !adj;

endmodule

// File: tb/tb_crtc_timing_gen.sv
// Directed bench for crtc_timing_gen: frame/line timing, MA/RA, adjust, cursor, reprogram, reset.
module tb_crtc_timing_gen;

    localparam int MAX_LEN = 400;

    logic        cclk_i;
    logic        reset_n_i;
    logic [13:0] screen_addr_i;
    logic [7:0]  h_char_total_i, h_char_displayed_i, h_sync_start_i;
    logic [3:0]  h_sync_width_i, v_sync_width_i;
    logic [4:0]  v_char_pixel_size_i, v_adjust_i, cursor_start_i, cursor_end_i;
    logic [6:0]  v_char_total_i, v_char_displayed_i, v_sync_start_i;
    logic [13:0] cursor_addr_i;
    logic [1:0]  cursor_mode_i;
    logic        display_enable_o, h_sync_o, v_sync_o, cursor_o, frame_start_o;
    logic [13:0] ma_o;
    logic [4:0]  ra_o;

    int checks = 0;
    int errors = 0;
    int len, de_n, hs_n, vs_n, cur_n, adj_de, fc;

    logic [13:0] ma_log  [MAX_LEN];
    logic [4:0]  ra_log  [MAX_LEN];
    logic        de_log  [MAX_LEN];
    logic        hs_log  [MAX_LEN];
    logic        vs_log  [MAX_LEN];
    logic        cur_log [MAX_LEN];

    crtc_timing_gen dut (
        .cclk_i              (cclk_i),
        .reset_n_i           (reset_n_i),
        .screen_addr_i       (screen_addr_i),
        .h_char_total_i      (h_char_total_i),
        .h_char_displayed_i  (h_char_displayed_i),
        .h_sync_start_i      (h_sync_start_i),
        .h_sync_width_i      (h_sync_width_i),
        .v_char_pixel_size_i (v_char_pixel_size_i),
        .v_char_total_i      (v_char_total_i),
        .v_char_displayed_i  (v_char_displayed_i),
        .v_sync_start_i      (v_sync_start_i),
        .v_sync_width_i      (v_sync_width_i),
        .v_adjust_i          (v_adjust_i),
        .cursor_addr_i       (cursor_addr_i),
        .cursor_start_i      (cursor_start_i),
        .cursor_end_i        (cursor_end_i),
        .cursor_mode_i       (cursor_mode_i),
        .display_enable_o    (display_enable_o),
        .h_sync_o            (h_sync_o),
        .v_sync_o            (v_sync_o),
        .ma_o                (ma_o),
        .ra_o                (ra_o),
        .cursor_o            (cursor_o),
        .frame_start_o       (frame_start_o)
    );

    initial begin
        cclk_i = 1'b0;
        forever #5 cclk_i = ~cclk_i;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge cclk_i);
        #1;
    endtask

    // Logs outputs cycle by cycle until the next frame_start_o (bounded)
    task automatic run_frame(output int n);
        n = 0;
        de_n = 0; hs_n = 0; vs_n = 0; cur_n = 0;
        do begin
            ma_log[n]  = ma_o;
            ra_log[n]  = ra_o;
            de_log[n]  = display_enable_o;
            hs_log[n]  = h_sync_o;
            vs_log[n]  = v_sync_o;
            cur_log[n] = cursor_o;
            de_n  += int'(display_enable_o);
            hs_n  += int'(h_sync_o);
            vs_n  += int'(v_sync_o);
            cur_n += int'(cursor_o);
            tick();
            n++;
        end while (!frame_start_o && n < MAX_LEN);
    endtask

    initial begin
        reset_n_i           = 1'b0;
        screen_addr_i       = 14'h0000;
        h_char_total_i      = 8'd5;
        h_char_displayed_i  = 8'd3;
        h_sync_start_i      = 8'd4;
        h_sync_width_i      = 4'd1;
        v_char_pixel_size_i = 5'd7;
        v_char_total_i      = 7'd4;
        v_char_displayed_i  = 7'd2;
        v_sync_start_i      = 7'd3;
        v_sync_width_i      = 4'd1;
        v_adjust_i          = 5'd0;
        cursor_addr_i       = 14'h0101;
        cursor_start_i      = 5'd6;
        cursor_end_i        = 5'd7;
        cursor_mode_i       = 2'b01;

        tick();
        tick();
        chk("rst_de",  32'(display_enable_o), 32'd0);
        chk("rst_fs",  32'(frame_start_o),    32'd0);
        chk("rst_ma",  32'(ma_o),             32'd0);
        chk("rst_ra",  32'(ra_o),             32'd0);
        chk("rst_hs",  32'(h_sync_o),         32'd0);
        chk("rst_vs",  32'(v_sync_o),         32'd0);
        chk("rst_cur", 32'(cursor_o),         32'd0);

        reset_n_i = 1'b1;
        #1;
        chk("first_fs", 32'(frame_start_o), 32'd1);

        // Frame 1: line/frame timing, row_start 0
        screen_addr_i = 14'h0100;
        run_frame(len);
        chk("f1_len",  32'(len),  32'd240);
        chk("f1_de_n", 32'(de_n), 32'd48);
        chk("f1_hs_n", 32'(hs_n), 32'd40);
        chk("f1_line_de", {26'd0, de_log[5], de_log[4], de_log[3], de_log[2], de_log[1], de_log[0]}, 32'b000111);
        chk("f1_line_hs", {26'd0, hs_log[5], hs_log[4], hs_log[3], hs_log[2], hs_log[1], hs_log[0]}, 32'b010000);
        chk("f1_vs_n",    32'(vs_n),        32'd6);
        chk("f1_vs_143",  32'(vs_log[143]), 32'd0);
        chk("f1_vs_144",  32'(vs_log[144]), 32'd1);
        chk("f1_vs_149",  32'(vs_log[149]), 32'd1);
        chk("f1_vs_150",  32'(vs_log[150]), 32'd0);

        // Frame 2: MA/RA from 0x100; cursor mode 01 must stay silent
        screen_addr_i = 14'h3FFF;
        run_frame(len);
        chk("f2_ma_0",  32'(ma_log[0]),  32'h100);
        chk("f2_ma_1",  32'(ma_log[1]),  32'h101);
        chk("f2_ma_2",  32'(ma_log[2]),  32'h102);
        chk("f2_ma_48", 32'(ma_log[48]), 32'h103);
        chk("f2_ma_49", 32'(ma_log[49]), 32'h104);
        chk("f2_ma_50", 32'(ma_log[50]), 32'h105);
        for (int k = 0; k < 8; k++)
            chk("f2_ra_sweep", 32'(ra_log[6*k]), 32'(k));
        chk("f2_ra_48",   32'(ra_log[48]), 32'd0);
        chk("f2_cur_off", 32'(cur_n),      32'd0);

        // Frame 3: address wrap
        screen_addr_i = 14'h0100;
        run_frame(len);
        chk("f3_ma_0", 32'(ma_log[0]), 32'h3FFF);
        chk("f3_ma_1", 32'(ma_log[1]), 32'h0000);
        chk("f3_ma_2", 32'(ma_log[2]), 32'h0001);

        // Frame 4: three adjust scanlines
        v_adjust_i = 5'd3;
        run_frame(len);
        adj_de = 0;
        for (int i = 240; i < 258; i++) adj_de += int'(de_log[i]);
        chk("f4_len",    32'(len),         32'd258);
        chk("f4_de_n",   32'(de_n),        32'd48);
        chk("f4_adj_de", 32'(adj_de),      32'd0);
        chk("f4_ra_240", 32'(ra_log[240]), 32'd0);
        chk("f4_ra_246", 32'(ra_log[246]), 32'd1);
        chk("f4_ra_252", 32'(ra_log[252]), 32'd2);

        // Frame 5 (frame_cnt 4): steady cursor
        v_adjust_i    = 5'd0;
        cursor_mode_i = 2'b00;
        run_frame(len);
        chk("f5_len",     32'(len),         32'd240);
        chk("f5_cur_n",   32'(cur_n),       32'd2);
        chk("f5_cur_r6",  32'(cur_log[37]), 32'd1);
        chk("f5_cur_r7",  32'(cur_log[43]), 32'd1);

        // 16-frame blink: frame_cnt 5..7 on, 8..15 off, 16 on
        cursor_mode_i = 2'b10;
        for (fc = 5; fc <= 16; fc++) begin
            run_frame(len);
            chk("blink16", 32'(cur_n), (fc & 8) != 0 ? 32'd0 : 32'd2);
        end

        // 32-frame blink at frame_cnt 17: bit 4 set, so off
        cursor_mode_i = 2'b11;
        run_frame(len);
        chk("blink32", 32'(cur_n), 32'd0);

        // Reprogram horizontal total mid-line (row_start 0x100)
        tick(); tick(); tick(); tick();
        chk("rp_ma_h4", 32'(ma_o), 32'h104);
        h_char_total_i = 8'd2;
        tick();
        chk("rp_wrap_ma", 32'(ma_o), 32'h100);
        chk("rp_wrap_ra", 32'(ra_o), 32'd1);
        tick();
        chk("rp_ma_h1", 32'(ma_o), 32'h101);
        tick();
        tick();
        chk("rp_short_ma", 32'(ma_o), 32'h100);
        chk("rp_short_ra", 32'(ra_o), 32'd2);

        // Resynchronise, then reset in the middle of a long vsync
        h_char_total_i = 8'd5;
        v_sync_width_i = 4'd4;
        run_frame(len);
        chk("resync_fs", 32'(frame_start_o), 32'd1);
        for (int i = 0; i < 152; i++) tick();
        chk("pre_rst_vs", 32'(v_sync_o), 32'd1);
        chk("pre_rst_ma", 32'(ma_o),     32'h10B);
        chk("pre_rst_ra", 32'(ra_o),     32'd1);
        reset_n_i = 1'b0;
        #1;
        chk("mid_rst_de",  32'(display_enable_o), 32'd0);
        chk("mid_rst_fs",  32'(frame_start_o),    32'd0);
        chk("mid_rst_ma",  32'(ma_o),             32'd0);
        chk("mid_rst_ra",  32'(ra_o),             32'd0);
        chk("mid_rst_hs",  32'(h_sync_o),         32'd0);
        chk("mid_rst_vs",  32'(v_sync_o),         32'd0);
        chk("mid_rst_cur", 32'(cursor_o),         32'd0);
        reset_n_i = 1'b1;
        #1;
        chk("post_rst_fs", 32'(frame_start_o),    32'd1);
        chk("post_rst_ma", 32'(ma_o),             32'd0);
        chk("post_rst_de", 32'(display_enable_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
